// File: rtl/voxel_ram_arbiter.sv
// Round-robin arbiter sharing one pipelined 1-bit voxel RAM read port
// among several DDA step-control cores; routes each solid bit back in order.
module voxel_ram_arbiter #(
    parameter int NUM_CORES   = 4,
    parameter int COORD_WIDTH = 16,
    parameter int GRID_LOG2   = 5,
    parameter int RAM_LATENCY = 2,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_CORES-1:0]               core_req,
    input  logic [NUM_CORES*COORD_WIDTH-1:0]   core_addr_x,
    input  logic [NUM_CORES*COORD_WIDTH-1:0]   core_addr_y,
    input  logic [NUM_CORES*COORD_WIDTH-1:0]   core_addr_z,
    output logic [NUM_CORES-1:0]               core_solid,
    output logic [NUM_CORES-1:0]               core_valid,
    output logic                               ram_en,
    output logic [3*GRID_LOG2-1:0]             ram_addr,
    input  logic                               ram_rdata,
    output logic                               busy,
    output logic [CNT_WIDTH-1:0]               grant_count,
    output logic [CNT_WIDTH-1:0]               stall_count
);

    localparam int AW  = 3 * GRID_LOG2;
    localparam int IDW = $clog2(NUM_CORES);

    typedef logic [IDW-1:0] id_t;

    logic [NUM_CORES-1:0]   in_flight_q, in_flight_d;
    id_t                    rr_ptr_q, rr_ptr_d;
    logic [RAM_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    id_t                    pipe_id_q [RAM_LATENCY];
    id_t                    pipe_id_d [RAM_LATENCY];
    logic [AW-1:0]          addr_q, addr_d;
    logic [NUM_CORES-1:0]   core_valid_q, core_valid_d;
    logic [NUM_CORES-1:0]   core_solid_q, core_solid_d;
    logic [CNT_WIDTH-1:0]   grant_count_q, grant_count_d;
    logic [CNT_WIDTH-1:0]   stall_count_q, stall_count_d;

    logic [NUM_CORES-1:0]   eligible;
    logic [AW-1:0]          packed_addr [NUM_CORES];
    logic                   grant;
    id_t                    winner;
    logic                   multi_elig;
    logic                   tail_vld;
    id_t                    tail_id;

    // Coordinate bits above the grid size are simply dropped.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            packed_addr[i] = {core_addr_z[i*COORD_WIDTH +: GRID_LOG2],
                              core_addr_y[i*COORD_WIDTH +: GRID_LOG2],
                              core_addr_x[i*COORD_WIDTH +: GRID_LOG2]};
        end
    end

    assign eligible = core_req & ~in_flight_q & {NUM_CORES{~reset}};

    always_comb begin
        grant      = 1'b0;
        winner     = '0;
        multi_elig = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NUM_CORES;
            if (!grant && eligible[idx]) begin
                grant  = 1'b1;
                winner = id_t'(idx);
            end else if (grant && eligible[idx]) begin
                multi_elig = 1'b1;
            end
        end
    end

    assign tail_vld = pipe_vld_q[RAM_LATENCY-1];
    assign tail_id  = pipe_id_q[RAM_LATENCY-1];

    always_comb begin
        ram_en   = grant;
        ram_addr = grant ? packed_addr[winner] : addr_q;
        addr_d   = ram_addr;

        pipe_vld_d[0] = grant;
        pipe_id_d[0]  = winner;
        for (int s = 1; s < RAM_LATENCY; s++) begin
            pipe_vld_d[s] = pipe_vld_q[s-1];
            pipe_id_d[s]  = pipe_id_q[s-1];
        end

        core_valid_d = '0;
        core_solid_d = '0;
        if (tail_vld) begin
            core_valid_d[tail_id] = 1'b1;
            core_solid_d[tail_id] = ram_rdata;
        end

        // A core stays blocked through its own response cycle.
        in_flight_d = in_flight_q & ~core_valid_q;
        if (grant) begin
            in_flight_d[winner] = 1'b1;
        end

        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            if (winner == id_t'(NUM_CORES - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = winner + 1'b1;
            end
        end

        grant_count_d = grant_count_q;
        if (grant && !(&grant_count_q)) begin
            grant_count_d = grant_count_q + 1'b1;
        end

        stall_count_d = stall_count_q;
        if (multi_elig && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_flight_q   <= '0;
            rr_ptr_q      <= '0;
            pipe_vld_q    <= '0;
            addr_q        <= '0;
            core_valid_q  <= '0;
            core_solid_q  <= '0;
            grant_count_q <= '0;
            stall_count_q <= '0;
            for (int s = 0; s < RAM_LATENCY; s++) begin
                pipe_id_q[s] <= '0;
            end
        end else begin
            in_flight_q   <= in_flight_d;
            rr_ptr_q      <= rr_ptr_d;
            pipe_vld_q    <= pipe_vld_d;
            addr_q        <= addr_d;
            core_valid_q  <= core_valid_d;
            core_solid_q  <= core_solid_d;
            grant_count_q <= grant_count_d;
            stall_count_q <= stall_count_d;
            for (int s = 0; s < RAM_LATENCY; s++) begin
                pipe_id_q[s] <= pipe_id_d[s];
            end
        end
    end

    assign core_valid  = core_valid_q;
    assign core_solid  = core_solid_q;
    assign busy        = |in_flight_q;
    assign grant_count = grant_count_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_voxel_ram_arbiter.sv
// Bench for voxel_ram_arbiter: queue-based reference model checked every
// cycle, a delay-line RAM model, and a narrow-counter instance for saturation.
module tb_voxel_ram_arbiter;

    localparam int N    = 4;
    localparam int CW   = 16;
    localparam int GL   = 5;
    localparam int L    = 2;
    localparam int CNTW = 32;
    localparam int AW   = 3 * GL;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    core_req;
    logic [N*CW-1:0] ax, ay, az;
    logic [N-1:0]    core_solid, core_valid;
    logic            ram_en;
    logic [AW-1:0]   ram_addr;
    logic            ram_rdata;
    logic            busy;
    logic [CNTW-1:0] grant_count, stall_count;

    logic [N-1:0]    s_solid, s_valid;
    logic            s_en, s_busy;
    logic [AW-1:0]   s_addr;
    logic [1:0]      s_gcnt, s_scnt;

    always #5 clock = ~clock;

    voxel_ram_arbiter #(.NUM_CORES(N), .COORD_WIDTH(CW), .GRID_LOG2(GL),
                        .RAM_LATENCY(L), .CNT_WIDTH(CNTW)) dut (
        .clock(clock), .reset(reset), .core_req(core_req),
        .core_addr_x(ax), .core_addr_y(ay), .core_addr_z(az),
        .core_solid(core_solid), .core_valid(core_valid),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .busy(busy), .grant_count(grant_count), .stall_count(stall_count)
    );

    voxel_ram_arbiter #(.NUM_CORES(N), .COORD_WIDTH(CW), .GRID_LOG2(GL),
                        .RAM_LATENCY(L), .CNT_WIDTH(2)) sat (
        .clock(clock), .reset(reset), .core_req(core_req),
        .core_addr_x(ax), .core_addr_y(ay), .core_addr_z(az),
        .core_solid(s_solid), .core_valid(s_valid),
        .ram_en(s_en), .ram_addr(s_addr), .ram_rdata(ram_rdata),
        .busy(s_busy), .grant_count(s_gcnt), .stall_count(s_scnt)
    );

    // RAM model: occupancy bit is the parity of the address.
    function automatic logic mem_bit(input logic [AW-1:0] a);
        return ^a;
    endfunction

    logic          rq_en   [L] = '{default: 1'b0};
    logic [AW-1:0] rq_addr [L] = '{default: '0};

    always @(posedge clock) begin
        rq_en[0]   <= ram_en;
        rq_addr[0] <= ram_addr;
        for (int s = 1; s < L; s++) begin
            rq_en[s]   <= rq_en[s-1];
            rq_addr[s] <= rq_addr[s-1];
        end
    end

    // Idle cycles return 1 so a missing valid gate shows up as a stray bit.
    assign ram_rdata = rq_en[L-1] ? mem_bit(rq_addr[L-1]) : 1'b1;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] pack(input int i);
        return {az[i*CW +: GL], ay[i*CW +: GL], ax[i*CW +: GL]};
    endfunction

    typedef struct {
        int   id;
        int   due;
        logic solid;
    } resp_t;

    resp_t         resp_q[$];
    logic [N-1:0]  m_inflight;
    int            m_rr;
    longint        m_g, m_s;
    logic [AW-1:0] m_last;
    int            cyc = 0;
    logic [N-1:0]  valid_last = '0;
    int            vlog[$];

    always @(negedge clock) begin
        logic [N-1:0]  e, exp_v, exp_s;
        int            win, idx, nel;
        logic [AW-1:0] exp_a;
        valid_last = core_valid;
        if (reset) begin
            chk("rst_valid", 64'(core_valid), 64'(0));
            chk("rst_solid", 64'(core_solid), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_en", 64'(ram_en), 64'(0));
            chk("rst_gcnt", 64'(grant_count), 64'(0));
            chk("rst_scnt", 64'(stall_count), 64'(0));
            m_inflight = '0;
            m_rr       = 0;
            m_g        = 0;
            m_s        = 0;
            m_last     = '0;
            resp_q.delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (core_valid[i]) vlog.push_back(i);
            end
            exp_v = '0;
            exp_s = '0;
            if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
                exp_v[resp_q[0].id] = 1'b1;
                exp_s[resp_q[0].id] = resp_q[0].solid;
            end
            e   = core_req & ~m_inflight;
            nel = $countones(e);
            win = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (win < 0 && e[idx]) win = idx;
            end
            exp_a = (win >= 0) ? pack(win) : m_last;

            chk("valid", 64'(core_valid), 64'(exp_v));
            chk("solid", 64'(core_solid), 64'(exp_s));
            chk("ram_en", 64'(ram_en), 64'(win >= 0));
            chk("ram_addr", 64'(ram_addr), 64'(exp_a));
            chk("busy", 64'(busy), 64'(|m_inflight));
            chk("gcnt", 64'(grant_count), 64'(m_g));
            chk("scnt", 64'(stall_count), 64'(m_s));
            chk("sat_gcnt", 64'(s_gcnt), 64'((m_g > 3) ? 3 : m_g));
            chk("sat_scnt", 64'(s_scnt), 64'((m_s > 3) ? 3 : m_s));

            if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
                m_inflight[resp_q[0].id] = 1'b0;
                void'(resp_q.pop_front());
            end
            if (win >= 0) begin
                resp_q.push_back('{id: win, due: cyc + L + 1,
                                   solid: mem_bit(exp_a)});
                m_inflight[win] = 1'b1;
                m_rr   = (win + 1) % N;
                m_last = exp_a;
                m_g++;
            end
            if (nel >= 2) m_s++;
        end
        cyc++;
    end

    int remaining[N] = '{default: 0};

    task automatic tick();
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (valid_last[i] && remaining[i] > 0) remaining[i]--;
            core_req[i] = (remaining[i] > 0);
        end
    endtask

    task automatic set_xyz(input int i, input logic [CW-1:0] x,
                           input logic [CW-1:0] y, input logic [CW-1:0] z);
        ax[i*CW +: CW] = x;
        ay[i*CW +: CW] = y;
        az[i*CW +: CW] = z;
    endtask

    task automatic go(input int i, input int n);
        remaining[i] = n;
        core_req[i]  = 1'b1;
    endtask

    task automatic drain();
        int b;
        int pend;
        b = 0;
        do begin
            pend = 0;
            for (int i = 0; i < N; i++) pend += remaining[i];
            if (pend == 0 && resp_q.size() == 0 && m_inflight == '0) break;
            tick();
            b++;
        end while (b < 300);
        checks++;
        if (b >= 300) begin
            fails++;
            $display("FAIL drain: still pending after %0d cycles", b);
        end
        tick();
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        core_req = '0;
        ax = '0;
        ay = '0;
        az = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        tick();

        // Single request from core 1.
        set_xyz(1, 16'd3, 16'd4, 16'd5);
        go(1, 1);
        @(negedge clock);
        chk("t1_en", 64'(ram_en), 64'(1));
        chk("t1_addr", 64'(ram_addr), 64'h1483);
        tick();
        tick();
        tick();
        @(negedge clock);
        chk("t1_valid", 64'(core_valid), 64'b0010);
        chk("t1_solid", 64'(core_solid), 64'b0010);
        drain();
        chk("t1_gcnt", 64'(grant_count), 64'(1));

        // Reset right after a grant; late RAM data must be ignored.
        set_xyz(1, 16'd7, 16'd1, 16'd2);
        go(1, 1);
        @(negedge clock);
        chk("t5_en", 64'(ram_en), 64'(1));
        tick();
        reset     = 1'b1;
        remaining = '{default: 0};
        core_req  = '0;
        tick();
        reset = 1'b0;
        tick();
        @(negedge clock);
        chk("t5_valid", 64'(core_valid), 64'(0));
        chk("t5_busy", 64'(busy), 64'(0));
        chk("t5_gcnt", 64'(grant_count), 64'(0));
        chk("t5_scnt", 64'(stall_count), 64'(0));
        tick();
        tick();

        // All four at once, starting from rr_ptr 0.
        set_xyz(0, 16'd1, 16'd2, 16'd3);
        set_xyz(1, 16'hFFE3, 16'h0020, 16'h8007);
        set_xyz(2, 16'd31, 16'd31, 16'd31);
        set_xyz(3, 16'd0, 16'd17, 16'd9);
        for (int i = 0; i < N; i++) go(i, 1);
        @(negedge clock);
        chk("t2_addr0", 64'(ram_addr), 64'h0C41);
        tick();
        @(negedge clock);
        chk("t2_addr1", 64'(ram_addr), 64'h1C03);
        tick();
        tick();
        @(negedge clock);
        chk("t2_valid0", 64'(core_valid), 64'b0001);
        tick();
        tick();
        tick();
        @(negedge clock);
        chk("t2_valid3", 64'(core_valid), 64'b1000);
        drain();
        chk("t2_gcnt", 64'(grant_count), 64'(4));
        chk("t2_scnt", 64'(stall_count), 64'(3));

        // Core 2 holds its request; no regrant until after its response.
        set_xyz(2, 16'd2, 16'd9, 16'd20);
        go(2, 2);
        @(negedge clock);
        chk("t3_en0", 64'(ram_en), 64'(1));
        tick();
        @(negedge clock);
        chk("t3_en1", 64'(ram_en), 64'(0));
        chk("t3_hold", 64'(ram_addr), 64'h5122);
        tick();
        tick();
        @(negedge clock);
        chk("t3_valid", 64'(core_valid), 64'b0100);
        chk("t3_en3", 64'(ram_en), 64'(0));
        tick();
        @(negedge clock);
        chk("t3_en4", 64'(ram_en), 64'(1));
        drain();

        // Fairness between cores 0 and 3 (rr_ptr now points at 3).
        set_xyz(0, 16'd10, 16'd11, 16'd12);
        set_xyz(3, 16'd20, 16'd21, 16'd22);
        vlog.delete();
        go(0, 3);
        go(3, 3);
        drain();
        begin
            logic [23:0] order;
            order = '0;
            foreach (vlog[k]) order = {order[19:0], 4'(vlog[k])};
            chk("t4_order", 64'(order), 64'h303030);
            chk("t4_len", 64'(vlog.size()), 64'(6));
        end

        // Mixed staggered traffic.
        set_xyz(0, 16'h0123, 16'h4567, 16'h89AB);
        set_xyz(1, 16'd30, 16'd1, 16'd14);
        set_xyz(2, 16'hFFFF, 16'd0, 16'd6);
        go(0, 2);
        go(2, 3);
        tick();
        go(1, 2);
        drain();

        chk("sat_final", 64'(s_gcnt), 64'(3));
        chk("gcnt_final", 64'(grant_count), 64'(m_g));
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/voxel_ram_arbiter.md
Name: voxel_ram_arbiter

Overview:
- Shares one pipelined single-bit voxel occupancy RAM read port among NUM_CORES DDA step-control cores.
- Each core issues level requests while it waits for a voxel's solid bit. The arbiter grants round-robin, at most one grant per cycle.
- It packs the core's voxel coordinate into a flat RAM address and routes the returned solid bit back to the requesting core as a one-cycle valid pulse.
- It sits between the step-control cores and the voxel RAM macro.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..16).
- COORD_WIDTH, 16, width of each core's voxel coordinate per axis.
- GRID_LOG2, 5, log2 of grid edge length; RAM address width is 3*GRID_LOG2.
- RAM_LATENCY, 2, cycles from ram_en sampled high to ram_rdata valid (>=1).
- CNT_WIDTH, 32, width of performance counters.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- core_req  in  NUM_CORES  per-core read request (level); held high until that core's core_valid pulse.
- core_addr_x  in  NUM_CORES*COORD_WIDTH  packed X coordinates; core i uses slice [i*COORD_WIDTH +: COORD_WIDTH].
- core_addr_y  in  NUM_CORES*COORD_WIDTH  packed Y coordinates.
- core_addr_z  in  NUM_CORES*COORD_WIDTH  packed Z coordinates.
- core_solid  out  NUM_CORES  returned solid bit per core; valid only with core_valid.
- core_valid  out  NUM_CORES  one-cycle response pulse per core.
- ram_en  out  1  RAM read enable.
- ram_addr  out  3*GRID_LOG2  flat address {z[GRID_LOG2-1:0], y[GRID_LOG2-1:0], x[GRID_LOG2-1:0]}.
- ram_rdata  in  1  RAM read data, valid RAM_LATENCY cycles after ram_en.
- busy  out  1  at least one read is in flight.
- grant_count  out  CNT_WIDTH  total grants issued; saturating.
- stall_count  out  CNT_WIDTH  cycles with >=2 eligible requesters; saturating.

Behaviour:
- Reset values: all outputs 0. Also cleared: in_flight[] all 0, rr_ptr=0, response pipeline valid bits 0.
- Eligibility: eligible[i] = core_req[i] & ~in_flight[i].
- Arbitration (combinational, same cycle):
  - Search from index rr_ptr upward, wrapping modulo NUM_CORES; the first eligible core wins.
  - ram_en=1 and ram_addr = winner's packed address in that same cycle.
  - With no eligible core, ram_en=0 and ram_addr holds its previous value (registered mux select).
- On grant of core g at clock edge:
  - in_flight[g] set.
  - rr_ptr <= (g+1) mod NUM_CORES.
  - {valid=1, id=g} pushed into the response shift pipeline of depth RAM_LATENCY.
  - rr_ptr is unchanged when there is no grant.
- Response: when the pipeline tail is valid with id t, on the next edge core_valid[t]=1 and core_solid[t]=ram_rdata (registered). Total latency is grant cycle G -> core_valid high in cycle G+RAM_LATENCY+1.
- core_valid pulses exactly one cycle. All other core_valid bits and all core_solid bits not being returned are 0.
- in_flight[t] clears at the edge ending the core_valid[t] cycle. A core still asserting core_req during its core_valid cycle is not regranted in that cycle.
- Throughput: one grant per cycle. Responses return in grant order; no reordering.
- Address packing: coordinate bits above GRID_LOG2 are dropped. Bounds checking belongs to the cores; the arbiter never rejects a request.
- A core dropping core_req while in flight still receives its response; the arbiter never cancels.
- grant_count increments on every grant. stall_count increments on every cycle with popcount(eligible)>=2. Both hold at all-ones.
- busy = any in_flight bit set.
- Reset mid-operation: async clear of the pipeline and in_flight. RAM data arriving after reset deassertion for pre-reset grants is ignored; no spurious core_valid.

Test Plan:
- Single request, RAM_LATENCY=2: core 1 req with (x,y,z)=(3,4,5), GRID_LOG2=5 -> ram_en in cycle 0 with ram_addr=0x1483. RAM returns 1 -> core_valid=4'b0010 and core_solid[1]=1 in cycle 3 only; grant_count=1.
- All four cores request in cycle 0 with rr_ptr=0 -> grants in order 0,1,2,3 in cycles 0..3. Responses in cycles 3..6 in the same order. stall_count=3.
- Core 2 holds core_req high through its in-flight window and response cycle with no other requesters -> exactly one grant; next grant only after core_valid[2] cycle if core_req is still high.
- Fairness: cores 0 and 3 request continuously, re-asserting after each response -> grants alternate 0,3,0,3; neither core starves.
- Reset asserted in cycle 1 after a grant in cycle 0, released in cycle 2, RAM data still returned in cycle 2 -> no core_valid pulse. busy=0, counters=0, rr_ptr=0.
- Counter saturation: preload grant_count to all-ones via forced stimulus, issue a grant -> value stays all-ones.
